ctrl_user_seq: RTL and testbench

Sequencing controller for user sequence entry. Captures up to 16 keypad digits (4 bits each) into a 64-bit sequence word and drives the clear and load strobes of the 64-bit user-sequence register. Sits between the keypad decoder and that register, under the main game FSM, which starts each round and consumes `done`/`timeout`.

---
 rtl/ctrl_user_seq.sv | 194 +++++++++++++++++++
 tb/tb_ctrl_user_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_user_seq.sv
// ---------------------------------------------------------------------------
// ctrl_user_seq
//
// Sequencing controller for user sequence entry. Collects up to N_DIGITS
// keypad digits into one packed sequence word and drives the clear and load
// strobes of the downstream user-sequence register. The main game FSM starts
// each round with `start` and watches `done` / `timeout`.
//
// Ports
//   clk        in   system clock, rising edge
//   R          in   asynchronous active-low reset
//   start      in   begin a round (looked at in IDLE only)
//   round_len  in   digits wanted this round, legal 1..N_DIGITS
//   abort      in   cancel the round from CLEAR / CAPTURE / TOUT
//   key_valid  in   one-cycle strobe per key press
//   key        in   digit value, qualified by key_valid
//   data       out  assembled sequence (digit 0 in the low nibble)
//   E          out  load strobe to the user-sequence register
//   clr_user   out  clear strobe to the user-sequence register
//   busy       out  high whenever the FSM is not in IDLE
//   count      out  digits accepted so far this round
//   done       out  one-cycle pulse, round committed
//   timeout    out  one-cycle pulse, round abandoned for inactivity
//   dbg_state  out  current FSM state encoding, for observation only
//
// Handshake: key_valid/key is a strobe without back-pressure. A key is
// taken exactly when key_valid is high at a rising edge while the FSM is in
// CAPTURE and abort is low; every other key strobe is dropped silently.
//
// All outputs are registers or pure decodes of the state register, so no
// input reaches an output without passing through a flop.
// N_DIGITS*DIGIT_W is expected to be 64 to match the sequence register.
// ---------------------------------------------------------------------------
module ctrl_user_seq #(
  parameter int N_DIGITS = 16,
  parameter int DIGIT_W  = 4,
  parameter int TIMEOUT  = 50_000_000
) (
  input  logic                        clk,
  input  logic                        R,
  input  logic                        start,
  input  logic [4:0]                  round_len,
  input  logic                        abort,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key,
  output logic [N_DIGITS*DIGIT_W-1:0] data,
  output logic                        E,
  output logic                        clr_user,
  output logic                        busy,
  output logic [4:0]                  count,
  output logic                        done,
  output logic                        timeout,
  output logic [2:0]                  dbg_state
);

  // Timer only ever needs to hold 0..TIMEOUT-1.
  localparam int                 TIMER_W    = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam int                 IDX_W      = $clog2(N_DIGITS);
  localparam logic [4:0]         MAX_LEN    = 5'(N_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMMIT  = 3'd3,
    S_DONE    = 3'd4,
    S_TOUT    = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [N_DIGITS*DIGIT_W-1:0] r_data;
  logic [4:0]                  r_count;
  logic [4:0]                  r_len;
  logic [TIMER_W-1:0]          r_timer;

  logic                        w_start_ok;
  logic                        w_take_key;
  logic                        w_last_key;
  logic                        w_expired;
  logic [4:0]                  w_count_inc;
  logic [IDX_W-1:0]            w_idx;

  // A start with an out-of-range length is treated as if it never happened.
  assign w_start_ok  = start && (round_len != 5'd0) && (round_len <= MAX_LEN);

  // abort outranks both a key and timer expiry.
  assign w_take_key  = (r_state == S_CAPTURE) && key_valid && !abort;
  assign w_count_inc = r_count + 5'd1;
  assign w_last_key  = w_take_key && (w_count_inc == r_len);

  // A key in the expiry cycle wins: expiry only counts on a key-less cycle.
  assign w_expired   = (r_state == S_CAPTURE) && !key_valid && !abort &&
                       (r_timer == TIMER_LAST);

  // While capturing, count is always below N_DIGITS, so its low bits
  // address the nibble slot directly.
  assign w_idx       = r_count[IDX_W-1:0];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_next = abort ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (w_last_key) begin
          w_state_next = S_COMMIT;
        end else if (w_expired) begin
          w_state_next = S_TOUT;
        end
      end
      // The load must complete once issued, so abort is not looked at here.
      S_COMMIT: w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      // TOUT always returns to IDLE; an abort here lands in the same place.
      S_TOUT:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: latched length, sequence word, digit count, inactivity timer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_len   <= 5'd0;
      r_data  <= '0;
      r_count <= 5'd0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_len <= round_len;
          end
        end
        S_CLEAR: begin
          r_data  <= '0;
          r_count <= 5'd0;
          r_timer <= '0;
        end
        S_CAPTURE: begin
          if (w_take_key) begin
            r_data[int'(w_idx)*DIGIT_W +: DIGIT_W] <= key;
            r_count <= w_count_inc;
            r_timer <= '0;
          end else if (!abort && (r_timer != TIMER_LAST)) begin
            // Saturating: never wraps back to zero on its own.
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          // COMMIT, DONE, TOUT: data and count hold their values.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign data      = r_data;
  assign count     = r_count;
  assign clr_user  = (r_state == S_CLEAR);
  assign E         = (r_state == S_COMMIT);
  assign done      = (r_state == S_DONE);
  assign timeout   = (r_state == S_TOUT);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ctrl_user_seq.sv
// ---------------------------------------------------------------------------
// tb_ctrl_user_seq
//
// Self-checking bench for ctrl_user_seq with TIMEOUT shortened to 8.
// Each round is planned up front (length, digits, idle gaps, ending); the
// expected sequence word is packed from the planned digits, and the expected
// strobe timing follows from the cycle each key was presented.
// ---------------------------------------------------------------------------
module tb_ctrl_user_seq;

  localparam int TOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        R;
  logic        start;
  logic [4:0]  round_len;
  logic        abort;
  logic        key_valid;
  logic [3:0]  key;
  logic [63:0] data;
  logic        E;
  logic        clr_user;
  logic        busy;
  logic [4:0]  count;
  logic        done;
  logic        timeout;
  logic [2:0]  dbg_state;

  ctrl_user_seq #(
    .N_DIGITS (16),
    .DIGIT_W  (4),
    .TIMEOUT  (TOUT_CYC)
  ) dut (
    .clk       (clk),
    .R         (R),
    .start     (start),
    .round_len (round_len),
    .abort     (abort),
    .key_valid (key_valid),
    .key       (key),
    .data      (data),
    .E         (E),
    .clr_user  (clr_user),
    .busy      (busy),
    .count     (count),
    .done      (done),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- pulse monitor ----------------
  int n_e = 0, n_done = 0, n_tout = 0, n_clr = 0;
  always @(negedge clk) begin
    if (R) begin
      if (E)        n_e    <= n_e + 1;
      if (done)     n_done <= n_done + 1;
      if (timeout)  n_tout <= n_tout + 1;
      if (clr_user) n_clr  <= n_clr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [3:0] keys_a[16];
  int         gaps_a[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: full round, 1: silence after nkeys (timeout), 2: abort after nkeys
  task automatic do_round(input int len, input int mode, input int nkeys, input bit abort_commit);
    int          e0, d0, t0, c0;
    int          last_ref, tc, gap;
    bit          found;
    logic [63:0] exp_data;
    logic [63:0] pk;

    e0 = n_e; d0 = n_done; t0 = n_tout; c0 = n_clr;
    exp_data = '0;
    for (int i = 0; i < nkeys; i++) begin
      pk = {60'd0, keys_a[i]};
      exp_data = exp_data | (pk << (4 * i));
    end
    exp_q.push_back(exp_data);

    start = 1'b1; round_len = 5'(len);
    step();
    start = 1'b0; round_len = 5'($urandom_range(0, 31));
    // CLEAR cycle: a key here must be dropped
    check("clr_user_in_clear", clr_user, 1);
    check("busy_in_clear", busy, 1);
    key_valid = 1'b1; key = 4'($urandom_range(0, 15));
    step();
    key_valid = 1'b0;
    last_ref = cyc - 1;

    for (int i = 0; i < nkeys; i++) begin
      repeat (gaps_a[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1; round_len = 5'($urandom_range(1, 16));
        end
        step();
        start = 1'b0;
      end
      key_valid = 1'b1; key = keys_a[i];
      last_ref = cyc;
      step();
      key_valid = 1'b0;
      check("count_after_key", 64'(count), 64'(i + 1));
    end

    exp_data = exp_q.pop_front();
    if (mode == 0) begin
      check("E_after_last_key", E, 1);
      check("data_at_commit", data, exp_data);
      check("count_at_commit", 64'(count), 64'(len));
      if (abort_commit) abort = 1'b1;
      key_valid = 1'b1; key = 4'($urandom_range(0, 15));
      step();
      abort = 1'b0; key_valid = 1'b0;
      check("done_pulse", done, 1);
      check("E_one_cycle", E, 0);
      check("data_after_commit", data, exp_data);
      step();
      check("busy_low_after_done", busy, 0);
      key_valid = 1'b1; key = 4'($urandom_range(0, 15));
      step();
      key_valid = 1'b0;
      step();
      check("data_hold_idle", data, exp_data);
      check("count_hold_idle", 64'(count), 64'(len));
    end else if (mode == 1) begin
      found = 1'b0; tc = -1;
      for (int j = 0; j < 3 * TOUT_CYC && !found; j++) begin
        if (timeout) begin
          found = 1'b1; tc = cyc;
        end else begin
          step();
        end
      end
      check("timeout_seen", 64'(found), 1);
      check("timeout_cycle", 64'(tc), 64'(last_ref + TOUT_CYC + 1));
      check("count_at_timeout", 64'(count), 64'(nkeys));
      check("data_at_timeout", data, exp_data);
      step();
      check("busy_low_after_tout", busy, 0);
    end else begin
      gap = $urandom_range(0, TOUT_CYC - 1);
      repeat (gap) step();
      abort = 1'b1;
      key_valid = $urandom_range(0, 1) == 1; key = 4'($urandom_range(0, 15));
      step();
      abort = 1'b0; key_valid = 1'b0;
      check("busy_low_after_abort", busy, 0);
      check("count_after_abort", 64'(count), 64'(nkeys));
      check("data_after_abort", data, exp_data);
    end
    step();
    check("E_pulses", 64'(n_e - e0), (mode == 0) ? 64'd1 : 64'd0);
    check("done_pulses", 64'(n_done - d0), (mode == 0) ? 64'd1 : 64'd0);
    check("tout_pulses", 64'(n_tout - t0), (mode == 1) ? 64'd1 : 64'd0);
    check("clr_pulses", 64'(n_clr - c0), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, e0, mode, len, nk;

    R = 1'b0; start = 1'b0; round_len = 5'd0; abort = 1'b0;
    key_valid = 1'b0; key = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_count", 64'(count), 0);
    check("rst_strobes", {60'd0, E, clr_user, done, timeout}, 0);
    @(negedge clk);
    R = 1'b1;
    step();

    // Full 16-digit round, back-to-back keys 1..F,0
    for (int i = 0; i < 16; i++) begin
      keys_a[i] = 4'(i + 1);
      gaps_a[i] = 0;
    end
    do_round(16, 0, 16, 1'b0);
    check("full_round_data", data, 64'h0FEDCBA987654321);

    // Short round with 5-cycle gaps
    keys_a[0] = 4'hA; keys_a[1] = 4'hB; keys_a[2] = 4'hC;
    gaps_a[0] = 0;    gaps_a[1] = 5;    gaps_a[2] = 5;
    do_round(3, 0, 3, 1'b0);
    check("short_round_data", data, 64'h0000_0000_0000_0CBA);
    check("short_round_count", 64'(count), 3);

    // Timeout after two keys
    keys_a[0] = 4'h3; keys_a[1] = 4'h9; gaps_a[0] = 0; gaps_a[1] = 0;
    do_round(4, 1, 2, 1'b0);
    check("tout_count", 64'(count), 2);

    // Key on the expiry cycle is accepted
    keys_a[0] = 4'h5; keys_a[1] = 4'h6; gaps_a[0] = 1; gaps_a[1] = TOUT_CYC - 1;
    do_round(2, 0, 2, 1'b0);

    // Minimum round, abort during COMMIT is ignored
    keys_a[0] = 4'hE; gaps_a[0] = 0;
    do_round(1, 0, 1, 1'b1);

    // Illegal lengths
    foreach (keys_a[i]) keys_a[i] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      round_len = (i == 0) ? 5'd0 : (i == 1) ? 5'd17 : 5'($urandom_range(17, 31));
      step();
      start = 1'b0;
      check("illegal_start_idle", busy, 0);
    end

    // Abort during CLEAR
    c0 = n_clr; e0 = n_e;
    start = 1'b1; round_len = 5'd4;
    step();
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_clear_idle", busy, 0);
    step();
    check("abort_clear_no_E", 64'(n_e - e0), 0);

    // Reset in the middle of CAPTURE with five digits in
    start = 1'b1; round_len = 5'd10;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1; key = 4'(i + 7);
      step();
    end
    key_valid = 1'b0;
    check("pre_reset_count", 64'(count), 5);
    #2;
    R = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_count", 64'(count), 0);
    check("async_rst_data", data, 0);
    check("async_rst_E", E, 0);
    @(negedge clk);
    R = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1; key = 4'($urandom_range(1, 15));
      step();
    end
    key_valid = 1'b0;
    step();
    check("idle_keys_busy", busy, 0);
    check("idle_keys_count", 64'(count), 0);
    check("idle_keys_data", data, 0);

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 2);
      len  = $urandom_range(1, 16);
      nk   = (mode == 0) ? len : $urandom_range(0, len - 1);
      for (int i = 0; i < 16; i++) begin
        keys_a[i] = 4'($urandom_range(0, 15));
        gaps_a[i] = $urandom_range(0, TOUT_CYC - 1);
      end
      do_round(len, mode, nk, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
